motor_ramp_ctrl: RTL and testbench

Speed/direction sequencer for the H-bridge motor path. Accepts target speed and direction commands over a valid/ready handshake and drives the `pwm` block's `duty` input and the bridge `in1`/`in2` pins. Duty moves by soft-start/soft-stop ramps, and direction reversals always pass through zero duty and a coast dead-time. An emergency-stop input forces an immediate brake.

---
 rtl/motor_ramp_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_motor_ramp_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/motor_ramp_ctrl.sv
// Speed/direction sequencer for the H-bridge: soft-start/stop duty ramps,
// zero-duty coast dead-time on reversal, and an immediate emergency brake.
module motor_ramp_ctrl #(
  parameter int PWM_WIDTH  = 9,
  parameter int DUTY_MAX   = 320,
  parameter int RAMP_TICKS = 6000,
  parameter int DEAD_TICKS = 60000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_dir,
  input  logic [PWM_WIDTH-1:0] cmd_speed,
  input  logic                 estop,
  output logic [PWM_WIDTH-1:0] duty,
  output logic                 in1,
  output logic                 in2,
  output logic                 cur_dir,
  output logic                 at_speed,
  output logic                 busy
);

  // Counters keep at least one bit so a tick count of 1 still elaborates.
  localparam int STEP_W = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
  localparam int DEAD_W = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
  localparam logic [STEP_W-1:0]    STEP_LAST  = STEP_W'(RAMP_TICKS - 1);
  localparam logic [DEAD_W-1:0]    DEAD_LAST  = DEAD_W'(DEAD_TICKS - 1);
  localparam logic [PWM_WIDTH-1:0] DUTY_MAX_V = PWM_WIDTH'(DUTY_MAX);
  localparam logic [PWM_WIDTH-1:0] DUTY_ONE   = PWM_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAMP,
    ST_RUN,
    ST_DEAD,
    ST_ESTOP
  } state_t;

  state_t               state_q, state_d;
  logic [PWM_WIDTH-1:0] duty_q, duty_d;
  logic [PWM_WIDTH-1:0] tgt_speed_q, tgt_speed_d;
  logic                 tgt_dir_q, tgt_dir_d;
  logic                 cur_dir_q, cur_dir_d;
  logic                 in1_q, in1_d;
  logic                 in2_q, in2_d;
  logic [STEP_W-1:0]    step_cnt_q, step_cnt_d;
  logic [DEAD_W-1:0]    dead_cnt_q, dead_cnt_d;

  logic                 cmd_accept;
  logic                 dir_match;
  logic [PWM_WIDTH-1:0] clamped_speed;
  logic [PWM_WIDTH-1:0] step_goal;

  assign cmd_ready     = !rst && !estop && (state_q != ST_ESTOP);
  assign cmd_accept    = cmd_valid && cmd_ready;
  assign clamped_speed = (cmd_speed > DUTY_MAX_V) ? DUTY_MAX_V : cmd_speed;
  assign dir_match     = (tgt_dir_q == cur_dir_q);
  // A pending reversal must first ramp all the way down to zero.
  assign step_goal     = dir_match ? tgt_speed_q : '0;

  always_comb begin
    state_d     = state_q;
    duty_d      = duty_q;
    tgt_speed_d = tgt_speed_q;
    tgt_dir_d   = tgt_dir_q;
    cur_dir_d   = cur_dir_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    step_cnt_d  = step_cnt_q;
    dead_cnt_d  = dead_cnt_q;

    if (cmd_accept) begin
      tgt_speed_d = clamped_speed;
      tgt_dir_d   = cmd_dir;
    end

    if (estop) begin
      state_d     = ST_ESTOP;
      duty_d      = '0;
      in1_d       = 1'b1;
      in2_d       = 1'b1;
      tgt_speed_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          duty_d = '0;
          in1_d  = 1'b0;
          in2_d  = 1'b0;
          if (tgt_speed_q != '0) begin
            cur_dir_d  = tgt_dir_q;
            in1_d      = !tgt_dir_q;
            in2_d      = tgt_dir_q;
            step_cnt_d = '0;
            state_d    = ST_RAMP;
          end
        end

        ST_RAMP: begin
          if (dir_match && (duty_q == tgt_speed_q)) begin
            if (tgt_speed_q != '0) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_IDLE;
              in1_d   = 1'b0;
              in2_d   = 1'b0;
            end
          end else if (!dir_match && (duty_q == '0)) begin
            state_d    = ST_DEAD;
            dead_cnt_d = '0;
            in1_d      = 1'b0;
            in2_d      = 1'b0;
          end else if (step_cnt_q == STEP_LAST) begin
            step_cnt_d = '0;
            if (duty_q < step_goal) begin
              duty_d = duty_q + DUTY_ONE;
            end else if (duty_q > step_goal) begin
              duty_d = duty_q - DUTY_ONE;
            end
          end else begin
            step_cnt_d = step_cnt_q + 1'b1;
          end
        end

        ST_RUN: begin
          if ((tgt_speed_q != duty_q) || !dir_match) begin
            state_d    = ST_RAMP;
            step_cnt_d = '0;
          end
        end

        ST_DEAD: begin
          duty_d = '0;
          in1_d  = 1'b0;
          in2_d  = 1'b0;
          if (dead_cnt_q == DEAD_LAST) begin
            if (tgt_speed_q != '0) begin
              cur_dir_d  = tgt_dir_q;
              in1_d      = !tgt_dir_q;
              in2_d      = tgt_dir_q;
              step_cnt_d = '0;
              state_d    = ST_RAMP;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            dead_cnt_d = dead_cnt_q + 1'b1;
          end
        end

        ST_ESTOP: begin
          // Released: coast through a full dead-time before anything restarts.
          state_d    = ST_DEAD;
          dead_cnt_d = '0;
          duty_d     = '0;
          in1_d      = 1'b0;
          in2_d      = 1'b0;
        end

        default: begin
          state_d = ST_IDLE;
          duty_d  = '0;
          in1_d   = 1'b0;
          in2_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      duty_q      <= '0;
      tgt_speed_q <= '0;
      tgt_dir_q   <= 1'b0;
      cur_dir_q   <= 1'b0;
      in1_q       <= 1'b0;
      in2_q       <= 1'b0;
      step_cnt_q  <= '0;
      dead_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      tgt_speed_q <= tgt_speed_d;
      tgt_dir_q   <= tgt_dir_d;
      cur_dir_q   <= cur_dir_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      step_cnt_q  <= step_cnt_d;
      dead_cnt_q  <= dead_cnt_d;
    end
  end

  assign duty     = duty_q;
  assign in1      = in1_q;
  assign in2      = in2_q;
  assign cur_dir  = cur_dir_q;
  assign at_speed = (state_q == ST_RUN);
  assign busy     = (state_q == ST_RAMP) || (state_q == ST_DEAD);

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl with RAMP_TICKS=4, DEAD_TICKS=8;
// expected values are hand-computed edge counts from the accepting edge.
module tb_motor_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_dir;
  logic [8:0] cmd_speed;
  logic       estop;
  logic [8:0] duty;
  logic       in1;
  logic       in2;
  logic       cur_dir;
  logic       at_speed;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  motor_ramp_ctrl #(
    .PWM_WIDTH (9),
    .DUTY_MAX  (320),
    .RAMP_TICKS(4),
    .DEAD_TICKS(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_dir  (cmd_dir),
    .cmd_speed(cmd_speed),
    .estop    (estop),
    .duty     (duty),
    .in1      (in1),
    .in2      (in2),
    .cur_dir  (cur_dir),
    .at_speed (at_speed),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents a command for exactly one edge (edge 0 of the caller's timeline).
  task automatic send_cmd(input logic dir, input logic [8:0] speed);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_speed = speed;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    $display("cmd dir=%0d speed=%0d -> duty=%0d in1=%0d in2=%0d", dir, speed, duty, in1, in2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_edges(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_speed = 9'd7; estop = 1'b0;
    wait_edges(2);
    n_checks++; if (duty !== 9'd0) begin n_fail++; $display("FAIL rst_duty: got %0d expected 0", duty); end
    n_checks++; if ({in1, in2} !== 2'b00) begin n_fail++; $display("FAIL rst_pins: got %b expected 00", {in1, in2}); end
    n_checks++; if (cur_dir !== 1'b0) begin n_fail++; $display("FAIL rst_cur_dir: got %0d expected 0", cur_dir); end
    n_checks++; if ({at_speed, busy} !== 2'b00) begin n_fail++; $display("FAIL rst_status: got %b expected 00", {at_speed, busy}); end
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_low: got %0d expected 0", cmd_ready); end
    cmd_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_high: got %0d expected 1", cmd_ready); end
    wait_edges(2);
    n_checks++; if ({in1, in2, busy} !== 3'b000) begin n_fail++; $display("FAIL rst_idle_hold: got %b expected 000", {in1, in2, busy}); end
  endtask

  task automatic test_soft_start();
    send_cmd(1'b0, 9'd10);
    n_checks++; if ({in1, in2} !== 2'b00) begin n_fail++; $display("FAIL ss_e0_pins: got %b expected 00", {in1, in2}); end
    wait_edges(1);
    n_checks++; if ({in1, in2, busy} !== 3'b101) begin n_fail++; $display("FAIL ss_e1_pins_busy: got %b expected 101", {in1, in2, busy}); end
    wait_edges(3);
    n_checks++; if (duty !== 9'd0) begin n_fail++; $display("FAIL ss_e4_duty: got %0d expected 0", duty); end
    wait_edges(1);
    n_checks++; if (duty !== 9'd1) begin n_fail++; $display("FAIL ss_e5_duty: got %0d expected 1", duty); end
    wait_edges(4);
    n_checks++; if (duty !== 9'd2) begin n_fail++; $display("FAIL ss_e9_duty: got %0d expected 2", duty); end
    wait_edges(31);
    n_checks++; if (duty !== 9'd9) begin n_fail++; $display("FAIL ss_e40_duty: got %0d expected 9", duty); end
    wait_edges(1);
    n_checks++; if ({duty, at_speed} !== {9'd10, 1'b0}) begin n_fail++; $display("FAIL ss_e41: duty=%0d at_speed=%0d expected 10/0", duty, at_speed); end
    wait_edges(1);
    n_checks++; if ({at_speed, busy} !== 2'b10) begin n_fail++; $display("FAIL ss_e42_status: got %b expected 10", {at_speed, busy}); end
  endtask

  task automatic test_reversal();
    send_cmd(1'b1, 9'd5);
    wait_edges(5);
    n_checks++; if ({duty, in1} !== {9'd9, 1'b1}) begin n_fail++; $display("FAIL rev_e5: duty=%0d in1=%0d expected 9/1", duty, in1); end
    wait_edges(36);
    n_checks++; if ({duty, in1, in2, busy} !== {9'd0, 3'b101}) begin n_fail++; $display("FAIL rev_e41: duty=%0d pins/busy=%b expected 0/101", duty, {in1, in2, busy}); end
    wait_edges(1);
    n_checks++; if ({in1, in2, busy} !== 3'b001) begin n_fail++; $display("FAIL rev_e42_dead: got %b expected 001", {in1, in2, busy}); end
    wait_edges(7);
    n_checks++; if ({in1, in2, cur_dir} !== 3'b000) begin n_fail++; $display("FAIL rev_e49_dead: got %b expected 000", {in1, in2, cur_dir}); end
    wait_edges(1);
    n_checks++; if ({in1, in2, cur_dir, duty} !== {3'b011, 9'd0}) begin n_fail++; $display("FAIL rev_e50: pins/dir=%b duty=%0d expected 011/0", {in1, in2, cur_dir}, duty); end
    wait_edges(20);
    n_checks++; if ({duty, at_speed} !== {9'd5, 1'b0}) begin n_fail++; $display("FAIL rev_e70: duty=%0d at_speed=%0d expected 5/0", duty, at_speed); end
    wait_edges(1);
    n_checks++; if (at_speed !== 1'b1) begin n_fail++; $display("FAIL rev_e71_run: got %0d expected 1", at_speed); end
  endtask

  task automatic test_clamp();
    send_cmd(1'b1, 9'd400);
    wait_edges(401);
    n_checks++; if (duty !== 9'd105) begin n_fail++; $display("FAIL clamp_e401: got %0d expected 105", duty); end
    wait_edges(860);
    n_checks++; if ({duty, at_speed} !== {9'd320, 1'b0}) begin n_fail++; $display("FAIL clamp_e1261: duty=%0d at_speed=%0d expected 320/0", duty, at_speed); end
    wait_edges(1);
    n_checks++; if ({at_speed, busy} !== 2'b10) begin n_fail++; $display("FAIL clamp_run: got %b expected 10", {at_speed, busy}); end
    wait_edges(10);
    n_checks++; if (duty !== 9'd320) begin n_fail++; $display("FAIL clamp_hold: got %0d expected 320", duty); end
  endtask

  task automatic test_estop();
    do_reset();
    send_cmd(1'b0, 9'd10);
    wait_edges(25);
    n_checks++; if (duty !== 9'd6) begin n_fail++; $display("FAIL es_pre_duty: got %0d expected 6", duty); end
    estop = 1'b1; cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_speed = 9'd50;
    #1;
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL es_ready_comb: got %0d expected 0", cmd_ready); end
    wait_edges(1);
    cmd_valid = 1'b0;
    n_checks++; if ({duty, in1, in2} !== {9'd0, 2'b11}) begin n_fail++; $display("FAIL es_brake: duty=%0d pins=%b expected 0/11", duty, {in1, in2}); end
    n_checks++; if ({cmd_ready, busy, at_speed} !== 3'b000) begin n_fail++; $display("FAIL es_status: got %b expected 000", {cmd_ready, busy, at_speed}); end
    wait_edges(3);
    n_checks++; if ({in1, in2} !== 2'b11) begin n_fail++; $display("FAIL es_hold: got %b expected 11", {in1, in2}); end
    estop = 1'b0;
    wait_edges(1);
    n_checks++; if ({in1, in2, busy, duty} !== {3'b001, 9'd0}) begin n_fail++; $display("FAIL es_rel_dead: got %b duty=%0d expected 001/0", {in1, in2, busy}, duty); end
    wait_edges(7);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL es_dead_last: got %0d expected 1", busy); end
    wait_edges(1);
    n_checks++; if ({busy, duty} !== {1'b0, 9'd0}) begin n_fail++; $display("FAIL es_idle: busy=%0d duty=%0d expected 0/0", busy, duty); end
    wait_edges(4);
    n_checks++; if ({in1, in2, busy} !== 3'b000) begin n_fail++; $display("FAIL es_cmd_ignored: got %b expected 000", {in1, in2, busy}); end
  endtask

  task automatic test_stop();
    do_reset();
    send_cmd(1'b0, 9'd3);
    wait_edges(14);
    n_checks++; if ({duty, at_speed} !== {9'd3, 1'b1}) begin n_fail++; $display("FAIL stop_pre: duty=%0d at_speed=%0d expected 3/1", duty, at_speed); end
    send_cmd(1'b0, 9'd0);
    wait_edges(5);
    n_checks++; if (duty !== 9'd2) begin n_fail++; $display("FAIL stop_e5: got %0d expected 2", duty); end
    wait_edges(4);
    n_checks++; if (duty !== 9'd1) begin n_fail++; $display("FAIL stop_e9: got %0d expected 1", duty); end
    wait_edges(4);
    n_checks++; if ({duty, in1, busy} !== {9'd0, 2'b11}) begin n_fail++; $display("FAIL stop_e13: duty=%0d in1/busy=%b expected 0/11", duty, {in1, busy}); end
    wait_edges(1);
    n_checks++; if ({in1, in2, busy} !== 3'b000) begin n_fail++; $display("FAIL stop_idle: got %b expected 000", {in1, in2, busy}); end
  endtask

  task automatic test_retarget_and_reset();
    do_reset();
    send_cmd(1'b0, 9'd4);
    wait_edges(18);
    n_checks++; if ({duty, at_speed} !== {9'd4, 1'b1}) begin n_fail++; $display("FAIL rt_pre: duty=%0d at_speed=%0d expected 4/1", duty, at_speed); end
    send_cmd(1'b0, 9'd8);
    wait_edges(1);
    send_cmd(1'b0, 9'd2);
    wait_edges(2);
    n_checks++; if (duty !== 9'd4) begin n_fail++; $display("FAIL rt_e4: got %0d expected 4", duty); end
    wait_edges(1);
    n_checks++; if (duty !== 9'd3) begin n_fail++; $display("FAIL rt_e5_no_rise: got %0d expected 3", duty); end
    wait_edges(4);
    n_checks++; if (duty !== 9'd2) begin n_fail++; $display("FAIL rt_e9: got %0d expected 2", duty); end
    wait_edges(1);
    n_checks++; if (at_speed !== 1'b1) begin n_fail++; $display("FAIL rt_run: got %0d expected 1", at_speed); end
    // Reverse to dir 1 so the reset has a non-default cur_dir to clear.
    send_cmd(1'b1, 9'd8);
    wait_edges(23);
    n_checks++; if ({duty, cur_dir, in1, in2} !== {9'd1, 3'b101}) begin n_fail++; $display("FAIL rr_pre: duty=%0d dir/pins=%b expected 1/101", duty, {cur_dir, in1, in2}); end
    rst = 1'b1;
    #1;
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rr_ready: got %0d expected 0", cmd_ready); end
    wait_edges(1);
    n_checks++; if ({duty, cur_dir, in1, in2, at_speed, busy} !== {9'd0, 5'b00000}) begin n_fail++; $display("FAIL rr_cleared: duty=%0d flags=%b expected 0/00000", duty, {cur_dir, in1, in2, at_speed, busy}); end
    rst = 1'b0;
    wait_edges(3);
    n_checks++; if ({in1, in2, busy, duty} !== {3'b000, 9'd0}) begin n_fail++; $display("FAIL rr_stays_idle: got %b duty=%0d expected 000/0", {in1, in2, busy}, duty); end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_speed = '0; estop = 1'b0;
    test_reset();
    test_soft_start();
    test_reversal();
    test_clamp();
    test_estop();
    test_stop();
    test_retarget_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
